// File: rtl/rs_pkg.sv
// Shared RS(68,64) definitions used by the parity encoder and the codeword serializer.
package rs_pkg;

    localparam int N_MSG = 64;              // message bytes per codeword
    localparam int N_PAR = 4;               // parity bytes per codeword
    localparam int DW    = 8;               // symbol width in bits
    localparam int N_CW  = N_MSG + N_PAR;   // bytes per codeword
    localparam int IDX_W = 7;               // width of the stream byte index

    typedef logic [DW-1:0]    sym_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_PAR = 2'd1,
        STREAM   = 2'd2
    } ser_state_t;

    // Index of the final codeword byte; the beat at this index carries out_last.
    localparam idx_t IDX_LAST = idx_t'(N_CW - 1);

endpackage

// File: rtl/rs_codeword_serializer.sv
// Merges a parallel 64-byte message with the 4 parity bytes returned one cycle later
// by the encoder, and streams the 68-byte systematic codeword one byte per beat.
module rs_codeword_serializer
    import rs_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  sym_t [N_MSG-1:0] msg_in,
    input  logic             msg_valid,
    output logic             msg_ready,
    input  sym_t [N_PAR-1:0] parity_in,
    input  logic             parity_valid,
    output sym_t             out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             err_overflow,
    output logic             err_protocol
);

    localparam int MSG_AW = $clog2(N_MSG);
    localparam int PAR_AW = $clog2(N_PAR);

    // The byte index must be able to address every codeword byte.
    if (N_CW > (1 << IDX_W)) begin : g_idx_width_check
        $error("rs_codeword_serializer: N_MSG+N_PAR exceeds the idx range");
    end

    ser_state_t         r_state;
    ser_state_t         w_state_nxt;
    sym_t [N_MSG-1:0]   r_msg_buf;
    sym_t [N_PAR-1:0]   r_par_buf;
    idx_t               r_idx;
    logic               r_err_overflow;
    logic               r_err_protocol;

    logic               w_accept_msg;
    logic               w_accept_par;
    logic               w_beat;
    logic               w_streaming;
    logic [MSG_AW-1:0]  w_msg_sel;
    logic [PAR_AW-1:0]  w_par_sel;

    assign w_streaming  = (r_state == STREAM);
    assign msg_ready    = (r_state == IDLE);
    assign out_valid    = w_streaming;
    assign out_last     = w_streaming && (r_idx == IDX_LAST);
    assign err_overflow = r_err_overflow;
    assign err_protocol = r_err_protocol;

    // State register: the only control state of the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the capture/handshake strobes that steer the datapath.
    always_comb begin
        w_state_nxt  = r_state;
        w_accept_msg = 1'b0;
        w_accept_par = 1'b0;
        w_beat       = 1'b0;
        case (r_state)
            IDLE: begin
                if (msg_valid) begin
                    w_accept_msg = 1'b1;
                    w_state_nxt  = WAIT_PAR;
                end else begin
                    w_state_nxt  = IDLE;
                end
            end
            WAIT_PAR: begin
                // Unbounded wait: the encoder is trusted to answer eventually.
                if (parity_valid) begin
                    w_accept_par = 1'b1;
                    w_state_nxt  = STREAM;
                end else begin
                    w_state_nxt  = WAIT_PAR;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    w_beat = 1'b1;
                    if (out_last) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = STREAM;
                    end
                end else begin
                    w_state_nxt = STREAM;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Message and parity buffers, loaded only on their accepting cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msg_buf <= {(N_MSG*DW){1'b0}};
            r_par_buf <= {(N_PAR*DW){1'b0}};
        end else begin
            if (w_accept_msg) begin
                r_msg_buf <= msg_in;
            end
            if (w_accept_par) begin
                r_par_buf <= parity_in;
            end
        end
    end

    // Byte index: cleared when parity lands and when the last byte leaves, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= {IDX_W{1'b0}};
        end else if (w_accept_par) begin
            r_idx <= {IDX_W{1'b0}};
        end else if (w_beat) begin
            if (out_last) begin
                r_idx <= {IDX_W{1'b0}};
            end else begin
                r_idx <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_overflow <= 1'b0;
            r_err_protocol <= 1'b0;
        end else begin
            r_err_overflow <= r_err_overflow | (msg_valid & ~msg_ready);
            r_err_protocol <= r_err_protocol | (parity_valid & (r_state != WAIT_PAR));
        end
    end

    // Output byte select: message bytes first, then parity; forced to zero outside STREAM.
    always_comb begin
        w_msg_sel = MSG_AW'(r_idx);
        w_par_sel = PAR_AW'(r_idx - idx_t'(N_MSG));
        out_data  = {DW{1'b0}};
        if (w_streaming) begin
            if (r_idx < idx_t'(N_MSG)) begin
                out_data = r_msg_buf[w_msg_sel];
            end else begin
                out_data = r_par_buf[w_par_sel];
            end
        end else begin
            out_data = {DW{1'b0}};
        end
    end

endmodule

// File: tb/tb_rs_codeword_serializer.sv
// Directed bench for rs_codeword_serializer: nominal stream, backpressure, error flags,
// reset in mid-stream and back-to-back codewords with late parity.
module tb_rs_codeword_serializer;
    import rs_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    sym_t [N_MSG-1:0] msg_in;
    logic             msg_valid;
    logic             msg_ready;
    sym_t [N_PAR-1:0] parity_in;
    logic             parity_valid;
    sym_t             out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             err_overflow;
    logic             err_protocol;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    int t1;
    int t2;

    rs_codeword_serializer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .msg_in       (msg_in),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .parity_in    (parity_in),
        .parity_valid (parity_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .err_overflow (err_overflow),
        .err_protocol (err_protocol)
    );

    always #5 clk = ~clk;

    // Free-running count of rising edges, used for latency and period checks.
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Codeword byte k for a message of seed+i bytes and parity of pbase+j bytes.
    function automatic sym_t exp_byte(input sym_t seed, input sym_t pbase, input int k);
        if (k < N_MSG) return seed + 8'(k);
        else           return pbase + 8'(k - N_MSG);
    endfunction

    task automatic set_msg(input sym_t seed);
        for (int i = 0; i < N_MSG; i++) msg_in[i] = seed + 8'(i);
    endtask

    task automatic set_par(input sym_t pbase);
        for (int j = 0; j < N_PAR; j++) parity_in[j] = pbase + 8'(j);
    endtask

    // Called at a falling edge with the block in IDLE; returns at the falling edge where
    // the first beat should be visible.
    task automatic send_cw(input sym_t seed, input sym_t pbase, input int late,
                           input bit dup_par, output int t_acc);
        set_msg(seed);
        msg_valid = 1'b1;
        if (dup_par) begin
            set_par(8'h55);
            parity_valid = 1'b1;
        end
        @(negedge clk);
        t_acc        = cyc_cnt;
        msg_valid    = 1'b0;
        parity_valid = 1'b0;
        chk("accept_ready_low", 32'(msg_ready), 32'd0);
        chk("wait_no_valid", 32'(out_valid), 32'd0);
        repeat (late) begin
            @(negedge clk);
            chk("wait_par_hold", 32'({msg_ready, out_valid}), 32'd0);
        end
        set_par(pbase);
        parity_valid = 1'b1;
        @(negedge clk);
        parity_valid = 1'b0;
        chk("first_valid", 32'(out_valid), 32'd1);
    endtask

    // Drains one codeword. mode 0: always ready, 1: 1,0,0,1,0,1 pattern, 2: random.
    // inj_beat pulses msg_valid with other data at that beat; rst_beat resets there.
    task automatic collect(input sym_t seed, input sym_t pbase, input int mode,
                           input int inj_beat, input int rst_beat);
        int   k       = 0;
        int   cyc     = 0;
        int   pat     = 0;
        logic stalled = 1'b0;
        logic rdy;
        sym_t pd      = 8'h00;
        logic pl      = 1'b0;
        while (k < N_CW && cyc < 1000) begin
            chk("valid_hold", 32'(out_valid), 32'd1);
            if (!out_valid) break;
            chk("beat_data", 32'(out_data), 32'(exp_byte(seed, pbase, k)));
            chk("beat_last", 32'(out_last), 32'(k == N_CW - 1));
            if (stalled) begin
                chk("stall_data", 32'(out_data), 32'(pd));
                chk("stall_last", 32'(out_last), 32'(pl));
            end
            if (k == rst_beat) begin
                out_ready = 1'b0;
                rst_n     = 1'b0;
                #1;
                chk("rst_valid_low", 32'(out_valid), 32'd0);
                chk("rst_ready_high", 32'(msg_ready), 32'd1);
                chk("rst_data_zero", 32'(out_data), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                chk("rst_release_ready", 32'(msg_ready), 32'd1);
                chk("rst_release_valid", 32'(out_valid), 32'd0);
                chk("rst_err_clear", 32'({err_overflow, err_protocol}), 32'd0);
                return;
            end
            if (k == inj_beat) begin
                set_msg(8'hC0);
                msg_valid = 1'b1;
            end else begin
                msg_valid = 1'b0;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((pat % 6) == 0) || ((pat % 6) == 3) || ((pat % 6) == 5);
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            pat++;
            out_ready = rdy;
            stalled   = !rdy;
            pd        = out_data;
            pl        = out_last;
            if (rdy) k++;
            @(negedge clk);
            cyc++;
        end
        msg_valid = 1'b0;
        chk("beat_count", 32'(k), 32'(N_CW));
        chk("ready_after_last", 32'(msg_ready), 32'd1);
        chk("idle_no_valid", 32'(out_valid), 32'd0);
        chk("idle_data_zero", 32'(out_data), 32'd0);
        chk("idle_last_zero", 32'(out_last), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        msg_valid    = 1'b0;
        parity_valid = 1'b0;
        out_ready    = 1'b0;
        msg_in       = '0;
        parity_in    = '0;
        repeat (2) @(negedge clk);
        chk("reset_msg_ready", 32'(msg_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_last", 32'(out_last), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_err_ovf", 32'(err_overflow), 32'd0);
        chk("reset_err_prot", 32'(err_protocol), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal codeword: 01..40h then A0..A3, ready held high.
        out_ready = 1'b1;
        send_cw(8'h01, 8'hA0, 0, 1'b0, t1);
        collect(8'h01, 8'hA0, 0, -1, -1);

        // Backpressure with the fixed pattern, then random.
        @(negedge clk);
        send_cw(8'h11, 8'hB0, 0, 1'b0, t1);
        collect(8'h11, 8'hB0, 1, -1, -1);
        @(negedge clk);
        send_cw(8'h81, 8'h3C, 0, 1'b0, t1);
        collect(8'h81, 8'h3C, 2, -1, -1);

        // Overflow: a second message at beat 10 is dropped and flagged.
        chk("ovf_before", 32'(err_overflow), 32'd0);
        @(negedge clk);
        send_cw(8'h21, 8'hB8, 0, 1'b0, t1);
        collect(8'h21, 8'hB8, 1, 10, -1);
        chk("ovf_set", 32'(err_overflow), 32'd1);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", 32'(err_overflow), 32'd1);
        chk("ovf_no_prot", 32'(err_protocol), 32'd0);

        // Protocol error: parity_valid while IDLE.
        parity_valid = 1'b1;
        @(negedge clk);
        parity_valid = 1'b0;
        chk("prot_set", 32'(err_protocol), 32'd1);
        chk("prot_no_valid", 32'(out_valid), 32'd0);
        chk("prot_ready", 32'(msg_ready), 32'd1);
        @(negedge clk);
        chk("prot_sticky", 32'(err_protocol), 32'd1);
        chk("prot_still_idle", 32'({msg_ready, out_valid}), 32'd2);

        // Reset at beat 30 of a stalled stream, then a clean codeword from byte 0.
        send_cw(8'h31, 8'hC4, 0, 1'b0, t1);
        collect(8'h31, 8'hC4, 1, -1, 30);
        out_ready = 1'b1;
        send_cw(8'h01, 8'hA0, 0, 1'b0, t1);
        collect(8'h01, 8'hA0, 0, -1, -1);

        // Back-to-back: next message on the first ready cycle, parity 3 cycles late.
        @(negedge clk);
        send_cw(8'h41, 8'hD0, 0, 1'b0, t1);
        collect(8'h41, 8'hD0, 0, -1, -1);
        send_cw(8'h51, 8'hE0, 3, 1'b0, t2);
        chk("b2b_period", 32'(t2 - t1), 32'd70);
        collect(8'h51, 8'hE0, 2, -1, -1);

        // Message and parity together in IDLE: message taken, stray parity flagged.
        chk("dup_prot_before", 32'(err_protocol), 32'd0);
        @(negedge clk);
        send_cw(8'h61, 8'hF0, 0, 1'b1, t1);
        chk("dup_prot_set", 32'(err_protocol), 32'd1);
        collect(8'h61, 8'hF0, 0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
